// File: rtl/alarm_arm_ctrl.sv
// alarm_arm_ctrl
//   Alarm arming/disarming controller. It synchronizes the asynchronous
//   inputs and debounces the IR sensor. It runs the
//   DISARMED -> EXIT_DELAY -> ARMED -> TRIGGERED -> LOCKOUT state machine
//   against a programmable switch passcode. It drives oVideo_On, which
//   enables the downstream video pipeline.
//
// Ports
//   iCLK        system clock (CLOCK_50)
//   iRST        synchronous reset, active-high
//   iSENSE      raw IR motion sensor (async)
//   iSW[9:0]    switch bank used as passcode (async, slow)
//   iARM        arm request level (async)
//   iENTER      code-entry request level (async)
//   iSET_CODE   program-passcode request level (async)
//   oVideo_On   high in TRIGGERED and LOCKOUT
//   oArmed      high in EXIT_DELAY, ARMED, TRIGGERED, LOCKOUT
//   oLockout    high in LOCKOUT
//   oState[2:0] 0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 TRIGGERED, 4 LOCKOUT
//   oTries[2:0] wrong-code count
//   oSecs[5:0]  remaining seconds in EXIT_DELAY/LOCKOUT, else 0
//   oTick_1Hz   one-cycle pulse each second
module alarm_arm_ctrl #(
  parameter int          CLK_FREQ        = 50_000_000,
  parameter int          DEBOUNCE_CYCLES = 500_000,
  parameter int          ARM_DELAY_S     = 10,
  parameter int          LOCK_S          = 30,
  parameter int          MAX_TRIES       = 3,
  parameter logic [9:0]  DEFAULT_CODE    = 10'h112
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSENSE,
  input  logic [9:0] iSW,
  input  logic       iARM,
  input  logic       iENTER,
  input  logic       iSET_CODE,
  output logic       oVideo_On,
  output logic       oArmed,
  output logic       oLockout,
  output logic [2:0] oState,
  output logic [2:0] oTries,
  output logic [5:0] oSecs,
  output logic       oTick_1Hz
);

  localparam int PW = $clog2(CLK_FREQ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]    ARM_SECS   = 6'(ARM_DELAY_S);
  localparam logic [5:0]    LOCK_SECS  = 6'(LOCK_S);
  localparam logic [2:0]    TRIES_LAST = 3'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_TRIG     = 3'd3,
    S_LOCK     = 3'd4
  } state_t;

  // Wrong-code counter increment that never goes past the lockout threshold.
  function automatic logic [2:0] tries_sat_inc(input logic [2:0] t);
    if (t >= TRIES_LAST) return TRIES_LAST;
    return t + 3'd1;
  endfunction

  // ---- p0/p1: two-flop synchronizers, p2: previous value for edge detect
  logic       sense_p0, sense_p1;
  logic       arm_p0, arm_p1, arm_p2;
  logic       enter_p0, enter_p1, enter_p2;
  logic       setc_p0, setc_p1, setc_p2;
  logic [9:0] sw_p0, sw_p1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sense_p0 <= 1'b0; sense_p1 <= 1'b0;
      arm_p0   <= 1'b0; arm_p1   <= 1'b0; arm_p2   <= 1'b0;
      enter_p0 <= 1'b0; enter_p1 <= 1'b0; enter_p2 <= 1'b0;
      setc_p0  <= 1'b0; setc_p1  <= 1'b0; setc_p2  <= 1'b0;
      sw_p0    <= '0;   sw_p1    <= '0;
    end else begin
      sense_p0 <= iSENSE;    sense_p1 <= sense_p0;
      arm_p0   <= iARM;      arm_p1   <= arm_p0;   arm_p2   <= arm_p1;
      enter_p0 <= iENTER;    enter_p1 <= enter_p0; enter_p2 <= enter_p1;
      setc_p0  <= iSET_CODE; setc_p1  <= setc_p0;  setc_p2  <= setc_p1;
      sw_p0    <= iSW;       sw_p1    <= sw_p0;
    end
  end

  logic arm_edge, enter_edge, setc_edge;
  assign arm_edge   = arm_p1   & ~arm_p2;
  assign enter_edge = enter_p1 & ~enter_p2;
  assign setc_edge  = setc_p1  & ~setc_p2;

  // ---- debounce: a new level must persist for DEBOUNCE_CYCLES edges
  logic [DW-1:0] db_cnt;
  logic          sense_db;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      db_cnt   <= '0;
      sense_db <= 1'b0;
    end else if (sense_p1 == sense_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_MAX) begin
      sense_db <= sense_p1;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // ---- control state machine
  state_t        state_q, state_d;
  logic [5:0]    secs_q, secs_d;
  logic [2:0]    tries_q, tries_d;
  logic [9:0]    code_q, code_d;
  logic          sense_ref_q, sense_ref_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          video_q, armed_q, lock_q, tick_q;
  logic          tick, match, restart;

  assign tick  = (presc_q == PRESC_MAX);
  assign match = (sw_p1 == code_q);

  always_comb begin
    state_d     = state_q;
    secs_d      = secs_q;
    tries_d     = tries_q;
    code_d      = code_q;
    sense_ref_d = sense_ref_q;
    case (state_q)
      S_DISARMED: begin
        if (setc_edge) code_d = sw_p1;
        // Arming requires all switches down so the code is not left showing.
        if (arm_edge && (sw_p1 == '0)) begin
          state_d = S_EXIT;
          secs_d  = ARM_SECS;
        end
      end
      S_EXIT: begin
        if (enter_edge && match) begin
          state_d = S_DISARMED;
          secs_d  = '0;
        end else if (tick) begin
          if (secs_q == 6'd1) begin
            state_d     = S_ARMED;
            secs_d      = '0;
            sense_ref_d = sense_db;
          end else begin
            secs_d = secs_q - 6'd1;
          end
        end
      end
      S_ARMED: begin
        // Disarm wins over a simultaneous sensor trigger.
        if (enter_edge && match) begin
          state_d = S_DISARMED;
        end else if (sense_db != sense_ref_q) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (enter_edge) begin
          if (match) begin
            state_d = S_DISARMED;
            tries_d = '0;
          end else if (tries_q == TRIES_LAST) begin
            state_d = S_LOCK;
            secs_d  = LOCK_SECS;
            tries_d = '0;
          end else begin
            tries_d = tries_sat_inc(tries_q);
          end
        end
      end
      S_LOCK: begin
        if (tick) begin
          if (secs_q == 6'd1) begin
            state_d = S_TRIG;
            secs_d  = '0;
          end else begin
            secs_d = secs_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = S_DISARMED;
        secs_d  = '0;
        tries_d = '0;
      end
    endcase
  end

  // The prescaler realigns on entry so each countdown lasts whole seconds.
  assign restart = (state_d != state_q) && ((state_d == S_EXIT) || (state_d == S_LOCK));

  always_comb begin
    if (restart || tick) presc_d = '0;
    else                 presc_d = presc_q + 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= S_DISARMED;
      secs_q      <= '0;
      tries_q     <= '0;
      code_q      <= DEFAULT_CODE;
      sense_ref_q <= 1'b0;
      presc_q     <= '0;
      video_q     <= 1'b0;
      armed_q     <= 1'b0;
      lock_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      secs_q      <= secs_d;
      tries_q     <= tries_d;
      code_q      <= code_d;
      sense_ref_q <= sense_ref_d;
      presc_q     <= presc_d;
      // Flags are decoded from the next state so they align with oState.
      video_q     <= (state_d == S_TRIG) || (state_d == S_LOCK);
      armed_q     <= (state_d != S_DISARMED);
      lock_q      <= (state_d == S_LOCK);
      tick_q      <= (presc_d == PRESC_MAX);
    end
  end

  assign oState    = state_q;
  assign oSecs     = secs_q;
  assign oTries    = tries_q;
  assign oVideo_On = video_q;
  assign oArmed    = armed_q;
  assign oLockout  = lock_q;
  assign oTick_1Hz = tick_q;

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// tb_alarm_arm_ctrl
//   Directed-vector bench for alarm_arm_ctrl with scaled-down timing
//   (100 cycles per second, 4-cycle debounce, 3 s exit, 2 s lockout).
module tb_alarm_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense;
  logic [9:0] sw;
  logic       arm, enter, set_code;
  logic       video_on, armed, lockout, tick_1hz;
  logic [2:0] state, tries;
  logic [5:0] secs;

  int n_vec  = 0;
  int n_miss = 0;

  localparam int BTN_ARM = 0;
  localparam int BTN_ENTER = 1;
  localparam int BTN_SET = 2;

  always #5 clk = ~clk;

  alarm_arm_ctrl #(
    .CLK_FREQ(100), .DEBOUNCE_CYCLES(4), .ARM_DELAY_S(3),
    .LOCK_S(2), .MAX_TRIES(3), .DEFAULT_CODE(10'h112)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSENSE(sense), .iSW(sw),
    .iARM(arm), .iENTER(enter), .iSET_CODE(set_code),
    .oVideo_On(video_on), .oArmed(armed), .oLockout(lockout),
    .oState(state), .oTries(tries), .oSecs(secs), .oTick_1Hz(tick_1hz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [9:0] v);
    sw = v;
    wait_edges(3);
  endtask

  // One-cycle button pulse; returns 1 ns after the edge where the effect shows (E2).
  task automatic press(input int which);
    case (which)
      BTN_ARM:   arm      = 1'b1;
      BTN_ENTER: enter    = 1'b1;
      default:   set_code = 1'b1;
    endcase
    wait_edges(1);
    arm = 1'b0; enter = 1'b0; set_code = 1'b0;
    wait_edges(2);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_secs"}, secs, 0);
    chk({tag, "_tries"}, tries, 0);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_video"}, video_on, 0);
    chk({tag, "_lock"}, lockout, 0);
    chk({tag, "_tick"}, tick_1hz, 0);
  endtask

  // Arm with switches down, ride out the exit delay, then flip the sensor.
  task automatic arm_and_trigger(input string tag);
    set_sw(10'h000);
    press(BTN_ARM);
    chk({tag, "_exit"}, state, 1);
    wait_edges(300);
    chk({tag, "_armed"}, state, 2);
    sense = ~sense;
    wait_edges(6);
    chk({tag, "_pretrig"}, state, 2);
    wait_edges(1);
    chk({tag, "_trig"}, state, 3);
  endtask

  task automatic lock_out(input string tag);
    set_sw(10'h001);
    press(BTN_ENTER);
    chk({tag, "_t1"}, tries, 1);
    press(BTN_ENTER);
    chk({tag, "_t2"}, tries, 2);
    press(BTN_ENTER);
    chk({tag, "_lock_state"}, state, 4);
  endtask

  initial begin
    rst = 1'b1; sense = 1'b0; sw = '0;
    arm = 1'b0; enter = 1'b0; set_code = 1'b0;
    wait_edges(2);
    check_idle("rst");
    rst = 1'b0;

    // 1: arm and run the exit delay
    press(BTN_ARM);
    chk("t1_state_e2", state, 1);
    chk("t1_secs_e2", secs, 3);
    chk("t1_armed_e2", armed, 1);
    wait_edges(98);
    chk("t1_tick_lo", tick_1hz, 0);
    wait_edges(1);
    chk("t1_tick_hi", tick_1hz, 1);
    chk("t1_secs3", secs, 3);
    wait_edges(1);
    chk("t1_tick_end", tick_1hz, 0);
    chk("t1_secs2", secs, 2);
    wait_edges(100);
    chk("t1_secs1", secs, 1);
    wait_edges(99);
    chk("t1_exit_299", state, 1);
    wait_edges(1);
    chk("t1_armed_300", state, 2);
    chk("t1_secs0", secs, 0);
    chk("t1_video_off", video_on, 0);

    // 2: short glitch rejected, held level triggers at sync+5
    sense = 1'b1;
    wait_edges(3);
    sense = 1'b0;
    wait_edges(10);
    chk("t2_glitch", state, 2);
    sense = 1'b1;
    wait_edges(6);
    chk("t2_pre", state, 2);
    wait_edges(1);
    chk("t2_trig", state, 3);
    chk("t2_video", video_on, 1);

    // 3: correct default code disarms from TRIGGERED
    set_sw(10'h112);
    press(BTN_ENTER);
    chk("t3_state", state, 0);
    chk("t3_video", video_on, 0);
    chk("t3_tries", tries, 0);
    chk("t3_armed", armed, 0);

    // 4: three wrong codes -> lockout, enter ignored, expires after 200 cycles
    arm_and_trigger("t4");
    lock_out("t4");
    chk("t4_lockout", lockout, 1);
    chk("t4_tries0", tries, 0);
    chk("t4_secs", secs, 2);
    chk("t4_video", video_on, 1);
    sw = 10'h112;
    press(BTN_ENTER);
    chk("t4_enter_ign", state, 4);
    wait_edges(196);
    chk("t4_lock_199", state, 4);
    chk("t4_secs1", secs, 1);
    wait_edges(1);
    chk("t4_back_trig", state, 3);
    chk("t4_lock_off", lockout, 0);
    chk("t4_video_on", video_on, 1);

    // 5: program a new code and use it
    set_sw(10'h112);
    press(BTN_ENTER);
    chk("t5_disarm", state, 0);
    set_sw(10'h3C0);
    press(BTN_SET);
    chk("t5_set_state", state, 0);
    arm_and_trigger("t5");
    set_sw(10'h112);
    press(BTN_ENTER);
    chk("t5_old_rej", tries, 1);
    chk("t5_old_state", state, 3);
    set_sw(10'h3C0);
    press(BTN_ENTER);
    chk("t5_new_ok", state, 0);
    chk("t5_tries0", tries, 0);

    // 6: reset mid-countdown and mid-lockout, code restored, ARM needs sw==0
    set_sw(10'h000);
    press(BTN_ARM);
    chk("t6_exit", state, 1);
    wait_edges(50);
    rst = 1'b1;
    wait_edges(1);
    check_idle("t6_rst_exit");
    rst = 1'b0;
    arm_and_trigger("t6a");
    lock_out("t6");
    wait_edges(50);
    rst = 1'b1;
    wait_edges(1);
    check_idle("t6_rst_lock");
    rst = 1'b0;
    arm_and_trigger("t6b");
    set_sw(10'h3C0);
    press(BTN_ENTER);
    chk("t6_3c0_rej", tries, 1);
    set_sw(10'h112);
    press(BTN_ENTER);
    chk("t6_default_ok", state, 0);
    set_sw(10'h004);
    press(BTN_ARM);
    chk("t6_arm_sw_state", state, 0);
    chk("t6_arm_sw_armed", armed, 0);
    chk("t6_arm_sw_secs", secs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alarm_arm_ctrl.md
# alarm_arm_ctrl

Alarm arming and disarming controller for the surveillance system. It synchronizes and debounces the IR motion sensor, runs an arm/exit-delay/armed/triggered/lockout state machine against a programmable switch passcode, and produces `oVideo_On`. `oVideo_On` is the enable that gates the ADV7180 I2C configuration and the VGA overlay downstream. The block sits directly upstream of the video pipeline on the 50 MHz domain.

## Interface
- `CLK_FREQ`, 50_000_000, iCLK cycles per second; sets the 1 Hz prescaler
- `DEBOUNCE_CYCLES`, 500_000, cycles iSENSE must hold a new level before it is accepted (10 ms)
- `ARM_DELAY_S`, 10, exit delay in seconds
- `LOCK_S`, 30, lockout duration in seconds
- `MAX_TRIES`, 3, wrong codes allowed before lockout (1..7)
- `DEFAULT_CODE`, 10'h112, passcode after reset (SW1, SW4, SW8)
- `iCLK`  in  1  system clock (CLOCK_50)
- `iRST`  in  1  synchronous reset, active-high; one clock, synchronous
- `iSENSE`  in  1  raw IR sensor, asynchronous
- `iSW`  in  10  switch bank, asynchronous and slowly varying; sampled through the sync stage
- `iARM`  in  1  arm request, active-high level (inverted KEY), asynchronous
- `iENTER`  in  1  code-entry request, active-high level, asynchronous
- `iSET_CODE`  in  1  program-passcode request, active-high level, asynchronous
- `oVideo_On`  out  1  high in TRIGGERED and LOCKOUT
- `oArmed`  out  1  high in EXIT_DELAY, ARMED, TRIGGERED, LOCKOUT
- `oLockout`  out  1  high in LOCKOUT
- `oState`  out  3  0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 TRIGGERED, 4 LOCKOUT
- `oTries`  out  3  wrong-code count
- `oSecs`  out  6  remaining seconds in EXIT_DELAY/LOCKOUT, else 0
- `oTick_1Hz`  out  1  one-cycle pulse each second

## Operation
- Inputs and sync:
  - iSENSE, iARM, iENTER, iSET_CODE and iSW each pass through 2-flop synchronizers.
  - ARM, ENTER and SET_CODE act only on rising edges (sync2 & ~prev).
- Debounce:
  - A counter increments while sense_sync ≠ sense_db.
  - When it reaches DEBOUNCE_CYCLES-1, sense_db takes sense_sync and the counter clears.
  - The counter clears whenever sense_sync == sense_db.
- Prescaler:
  - Counts 0..CLK_FREQ-1 and pulses oTick_1Hz on the terminal count.
  - Restarts at 0 on every entry to EXIT_DELAY or LOCKOUT.
- Code match: `match = (sw_sync == code_reg)`.
- Transitions:
  - DISARMED:
    - SET_CODE edge: code_reg <= sw_sync.
    - ARM edge with sw_sync == 0: go to EXIT_DELAY with secs <= ARM_DELAY_S.
    - ARM edge with sw_sync ≠ 0 is ignored.
  - EXIT_DELAY:
    - Each tick decrements secs; a tick with secs == 1 goes to ARMED and latches sense_ref <= sense_db.
    - ENTER & match goes to DISARMED. ENTER & !match is ignored.
    - Sense is ignored.
  - ARMED:
    - sense_db ≠ sense_ref goes to TRIGGERED. Either edge of sense_db triggers.
    - ENTER & match goes to DISARMED.
  - TRIGGERED:
    - ENTER & match goes to DISARMED and tries <= 0.
    - ENTER & !match: tries + 1. If tries + 1 == MAX_TRIES, go to LOCKOUT with secs <= LOCK_S and tries <= 0.
  - LOCKOUT:
    - ENTER is ignored.
    - A tick with secs == 1 returns to TRIGGERED.
- Priority in one cycle: iRST > LOCKOUT expiry > ENTER > sense trigger > tick decrement.
  - ENTER & match and a sense trigger in the same ARMED cycle goes to DISARMED.
- SET_CODE outside DISARMED is ignored. code_reg is never changed by ENTER.
- tries saturates: it never exceeds MAX_TRIES-1 outside LOCKOUT.

## Timing
- Reset values:
  - State DISARMED and all outputs 0.
  - code_reg = DEFAULT_CODE.
  - sense_db = 0, sense_ref = 0.
  - Synchronizers and edge registers = 0.
  - Prescaler, debounce counter, tries and secs = 0.
- iRST asserted mid-countdown or mid-lockout: all of the above take effect at the next edge with no residual state.
- All outputs are registered.
- Button latency: the input is first sampled high at edge E0; state and outputs reflect it at E2.
- Sense latency: sense_sync changes at E1; sense_db changes DEBOUNCE_CYCLES edges later; TRIGGERED one edge after that.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Exit delay: exactly ARM_DELAY_S·CLK_FREQ cycles from EXIT_DELAY entry to ARMED.
- Lockout: exactly LOCK_S·CLK_FREQ cycles from LOCKOUT entry to TRIGGERED.
- oTick_1Hz: high for exactly one cycle per CLK_FREQ cycles.

## Test plan
All scenarios use CLK_FREQ=100, DEBOUNCE_CYCLES=4, ARM_DELAY_S=3, LOCK_S=2, MAX_TRIES=3.
1. Reset, iSW=0, ARM pulse -> oState=1 and oSecs=3 at E2; oSecs steps 3,2,1; oState=2 exactly 300 cycles after EXIT_DELAY entry.
2. In ARMED, iSENSE 3-cycle glitch -> no change; iSENSE held high -> oState=3 and oVideo_On=1 at sync+5 edges.
3. TRIGGERED, iSW=10'h112, ENTER pulse -> oState=0, oVideo_On=0, oTries=0.
4. TRIGGERED, three ENTER pulses with iSW=10'h001 -> oTries 1,2, then oState=4 and oLockout=1; ENTER with the correct code ignored; oState=3 after 200 cycles.
5. DISARMED, iSW=10'h3C0, SET_CODE -> arm, trigger; 10'h112 rejected (oTries=1); 10'h3C0 disarms.
6. iRST asserted during EXIT_DELAY and again during LOCKOUT -> next edge: oState=0, oSecs=0, all outputs 0, code restored to 10'h112; also ARM pulse with iSW≠0 -> stays DISARMED.
